// File: rtl/mr_ldst_pipe.sv
// mr_ldst_pipe: load/store unit issuing pipelined Wishbone requests, with an
// in-order metadata FIFO, misalignment traps and an error-abort drain.
module mr_ldst_pipe #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int INSTID_BITS = 4,
  parameter int REGSEL_BITS = 5,
  localparam int GRAN = $clog2(XLEN / 8),
  localparam int SZW = $clog2(GRAN + 1),
  localparam int BW = XLEN / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic [1:0]             ex_op_i,
  input  logic [SZW-1:0]         ex_size_i,
  input  logic                   ex_signed_i,
  input  logic [XLEN-1:0]        ex_addr_i,
  input  logic [XLEN-1:0]        ex_payload_i,
  input  logic [REGSEL_BITS-1:0] ex_dst_reg_i,
  input  logic [INSTID_BITS-1:0] ex_instid_i,
  output logic                   wb_valid_o,
  output logic [INSTID_BITS-1:0] wb_instid_o,
  output logic [REGSEL_BITS-1:0] wb_dst_reg_o,
  output logic [XLEN-1:0]        wb_data_o,
  output logic                   wb_fault_o,
  output logic [1:0]             wb_cause_o,
  output logic [XLEN-GRAN-1:0]   addr_o,
  output logic                   we_o,
  output logic [BW-1:0]          sel_o,
  output logic [XLEN-1:0]        dat_o,
  output logic                   stb_o,
  output logic                   cyc_o,
  input  logic                   ack_i,
  input  logic                   err_i,
  input  logic                   stall_i,
  input  logic [XLEN-1:0]        dat_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(XLEN);

  logic [CW-1:0] count;
  logic          abort;
  logic          stb;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [INSTID_BITS-1:0] f_id   [DEPTH];
  logic [REGSEL_BITS-1:0] f_dst  [DEPTH];
  logic [SZW-1:0]         f_size [DEPTH];
  logic [GRAN-1:0]        f_off  [DEPTH];
  logic                   f_sgn  [DEPTH];
  logic                   f_st   [DEPTH];

  logic            mem_op;
  logic            misal;
  logic            fast;
  logic [GRAN-1:0] off;
  logic [GRAN-1:0] lane_m;
  logic            cyc;
  logic            ack_v;
  logic            err_v;
  logic            drain;
  logic            pop;
  logic            ready;
  logic            acc;
  logic            push;
  logic            fast_acc;
  logic [BW-1:0]   sel_c;
  logic [XLEN-1:0] dat_c;

  logic [GRAN-1:0] h_off;
  logic [SZW-1:0]  h_size;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [LW-1:0]   sidx;
  logic            sgn;
  logic [XLEN-1:0] ld;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mem_op = (ex_op_i == 2'd1) || (ex_op_i == 2'd2);
  assign off    = ex_addr_i[GRAN-1:0];
  assign lane_m = GRAN'((32'd1 << ex_size_i) - 32'd1);
  assign misal  = mem_op && ((off & lane_m) != '0);
  assign fast   = !mem_op || misal;

  // An abort hides the bus: cyc drops and late ack/err are ignored.
  assign cyc   = !abort && (stb || (count != '0));
  assign err_v = err_i && cyc && (count != '0);
  assign ack_v = ack_i && !err_i && cyc && (count != '0);
  assign drain = abort && (count != '0);
  assign pop   = ack_v || err_v || drain;

  always_comb begin
    ready = 1'b0;
    if (!rst && !abort && !err_v) begin
      if (fast)
        ready = (count == '0) && !stb;
      else
        ready = (count < CW'(DEPTH)) && (!stb || !stall_i);
    end
  end

  assign acc      = ex_valid_i && ready;
  assign push     = acc && !fast;
  assign fast_acc = acc && fast;

  assign sel_c = BW'(((32'd1 << (32'd1 << ex_size_i)) - 32'd1) << off);

  always_comb begin
    dat_c = '0;
    for (int i = 0; i < BW; i++)
      dat_c[i*8 +: 8] = ex_payload_i[{GRAN'(i) & lane_m, 3'b000} +: 8];
  end

  assign h_off   = f_off[rd_ptr];
  assign h_size  = f_size[rd_ptr];
  assign shifted = dat_i >> {h_off, 3'b000};
  assign sidx    = LW'((32'd8 << h_size) - 32'd1);
  assign mask    = (h_size >= SZW'(GRAN)) ? {XLEN{1'b1}}
                 : XLEN'((64'd1 << (32'd8 << h_size)) - 64'd1);
  assign sgn     = f_sgn[rd_ptr] && shifted[sidx];
  assign ld      = (shifted & mask) | (sgn ? ~mask : '0);

  always_ff @(posedge clk) begin
    if (push) begin
      f_id[wr_ptr]   <= ex_instid_i;
      f_dst[wr_ptr]  <= ex_dst_reg_i;
      f_size[wr_ptr] <= ex_size_i;
      f_off[wr_ptr]  <= off;
      f_sgn[wr_ptr]  <= ex_signed_i;
      f_st[wr_ptr]   <= (ex_op_i == 2'd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      abort  <= 1'b0;
      stb    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr_o <= '0;
      we_o   <= 1'b0;
      sel_o  <= '0;
      dat_o  <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= nxt(wr_ptr);
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      if (err_v)
        abort <= 1'b1;
      else if (abort && (count == '0))
        abort <= 1'b0;
      if (push) begin
        stb    <= 1'b1;
        addr_o <= ex_addr_i[XLEN-1:GRAN];
        we_o   <= (ex_op_i == 2'd2);
        sel_o  <= sel_c;
        dat_o  <= dat_c;
      end else if (err_v || !stall_i) begin
        stb <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o   <= 1'b0;
      wb_instid_o  <= '0;
      wb_dst_reg_o <= '0;
      wb_data_o    <= '0;
      wb_fault_o   <= 1'b0;
      wb_cause_o   <= 2'd0;
    end else begin
      wb_valid_o <= fast_acc || pop;
      if (fast_acc) begin
        wb_instid_o  <= ex_instid_i;
        wb_dst_reg_o <= ex_dst_reg_i;
        wb_data_o    <= ex_addr_i;
        wb_fault_o   <= misal;
        wb_cause_o   <= misal ? 2'd1 : 2'd0;
      end else if (pop) begin
        wb_instid_o  <= f_id[rd_ptr];
        wb_dst_reg_o <= f_dst[rd_ptr];
        unique case (1'b1)
          ack_v: begin
            wb_data_o  <= f_st[rd_ptr] ? '0 : ld;
            wb_fault_o <= 1'b0;
            wb_cause_o <= 2'd0;
          end
          err_v: begin
            wb_data_o  <= '0;
            wb_fault_o <= 1'b1;
            wb_cause_o <= 2'd2;
          end
          default: begin
            wb_data_o  <= '0;
            wb_fault_o <= 1'b1;
            wb_cause_o <= 2'd3;
          end
        endcase
      end
    end
  end

  assign stb_o      = stb;
  assign cyc_o      = cyc;
  assign ex_ready_o = ready;

  ack_without_request: assert property (
    @(posedge clk) disable iff (rst) !(ack_i && (count == '0)));
  illegal_op: assert property (
    @(posedge clk) disable iff (rst) !(ex_valid_i && (ex_op_i == 2'd3)));

endmodule

// File: doc/mr_ldst_pipe.md
MR_LDST_PIPE -- requirements
Module: mr_ldst_pipe

Interface
REQ-001 Parameter XLEN, default 32: data/address width; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, default 4: max outstanding bus requests, power of two, 1..16.
REQ-003 Parameter INSTID_BITS, default 4; REGSEL_BITS, default 5: tag and register-select widths.
REQ-004 Localparam GRAN = log2(XLEN/8); SZW = log2(log2(XLEN/8)+1).
REQ-005 Ports (name dir width meaning):
- clk in 1 clock; one clock domain.
- rst in 1 asynchronous, active-high reset.
- ex_valid_i in 1 request valid.
- ex_ready_o out 1 request accepted when valid&ready.
- ex_op_i in 2: 0 none, 1 load, 2 store; 3 is illegal.
- ex_size_i in SZW: log2 of byte count, 0=1B up to GRAN.
- ex_signed_i in 1 sign-extend load.
- ex_addr_i in XLEN byte address; ALU result for op none.
- ex_payload_i in XLEN store data.
- ex_dst_reg_i in REGSEL_BITS destination register.
- ex_instid_i in INSTID_BITS tag.
- wb_valid_o out 1 result valid, one-cycle pulse; no backpressure.
- wb_instid_o out INSTID_BITS; wb_dst_reg_o out REGSEL_BITS; wb_data_o out XLEN.
- wb_fault_o out 1; wb_cause_o out 2: 0 none, 1 misaligned, 2 bus error, 3 aborted.
- addr_o out XLEN-GRAN word address; we_o out 1; sel_o out XLEN/8; dat_o out XLEN.
- stb_o out 1; cyc_o out 1 pipelined-Wishbone master.
- ack_i in 1; err_i in 1; stall_i in 1; dat_i in XLEN.

Function
REQ-006 Count = memory requests accepted, not yet acked/erred/aborted; range 0..DEPTH.
REQ-007 Memory op (1/2), aligned: ex_ready_o = !abort & count<DEPTH & (!stb_o | !stall_i); accept pushes tag/dst/size/signed/byte-offset into in-order metadata FIFO.
REQ-008 On acceptance, next cycle: stb_o=1, cyc_o=1, addr_o/we_o/sel_o/dat_o registered; stb_o and bus fields held constant while stall_i=1.
REQ-009 Back-to-back accepts SHALL issue one strobe per cycle when stall_i=0; stb_o drops when no new request accepted and !stall_i.
REQ-010 cyc_o = stb_o | count>0; deasserts cycle after last ack.
REQ-011 Store: dat_o = payload byte lane replicated across XLEN; sel_o = (2^(2^size)-1) << offset.
REQ-012 Load: sel_o as REQ-011; we_o=0.
REQ-013 Misaligned (addr mod 2^size != 0) or op none: accepted only when count==0 & !stb_o & !abort; no bus cycle.
REQ-014 Op none: next cycle wb_valid_o=1, wb_data_o=ex_addr_i, fault 0.
REQ-015 Misaligned: next cycle wb_valid_o=1, wb_fault_o=1, cause 1, wb_data_o=ex_addr_i.
REQ-016 ack_i pops FIFO head; next cycle wb_valid_o=1 with head tag/dst; load data shifted by offset, zero/sign-extended per size/signed; store data 0.
REQ-017 ack_i and accept in same cycle: count unchanged; ack with count==0 ignored, flagged by assertion.
REQ-018 err_i: pops head, reports cause 2 next cycle; stb_o, cyc_o drop next cycle; abort set.
REQ-019 Abort: remaining FIFO entries reported one per cycle, cause 3, fault 1, in order; ex_ready_o=0; bus inputs ignored; abort clears when FIFO empty.
REQ-020 ack_i/err_i while cyc_o=0 ignored.
REQ-021 Op 3 illegal: assertion; behaviour undefined.

Reset
REQ-022 rst asserted asynchronously clears stb_o, cyc_o, wb_valid_o, wb_fault_o, wb_cause_o, ex_ready_o, count, abort, FIFO pointers; bus data fields, wb data 0.
REQ-023 rst mid-transaction discards all in-flight entries without reporting; ex_ready_o returns 1 first cycle after deassert.

Verification
REQ-024 Load 1B signed addr 0x103, dat_i 0x80FFFFFF, ack after 2 cycles -> sel_o 4'b1000, wb_data_o 0xFFFFFF80, one wb_valid_o pulse.
REQ-025 Four loads back-to-back, stall_i=0, acks delayed 3 cycles, DEPTH=4 -> 4 strobes on consecutive cycles, 5th request held (ex_ready_o=0) until first ack, results in order.
REQ-026 Store 2B addr 0x202 payload 0xBEEF -> dat_o 0xBEEFBEEF, sel_o 4'b1100, we_o=1; held 3 cycles under stall_i.
REQ-027 Load 4B addr 0x301 -> no stb_o, wb_fault_o=1, cause 1, next cycle.
REQ-028 Three loads in flight, err_i on first -> cause 2 then two cause 3 pulses, cyc_o low next cycle after err, ready after drain.
REQ-029 rst pulse with 2 in flight -> all outputs 0 immediately, no wb_valid_o after release.
